// File: rtl/mux_channel_scanner_if.sv
// Bundles the scan request/result and 16:1 MUX signals of mux_channel_scanner.
// The slave modport is the scanner side; the master modport is the requester and MUX side.
interface mux_channel_scanner_if;
    logic        Start_In;
    logic [15:0] Channel_Mask_In;
    logic        MUX_Data_In;
    logic        MUX_Enable_Out;
    logic [3:0]  MUX_Select_Out;
    logic        Busy_Out;
    logic        Done_Out;
    logic [15:0] Scan_Data_Out;

    modport slave (
        input  Start_In,
        input  Channel_Mask_In,
        input  MUX_Data_In,
        output MUX_Enable_Out,
        output MUX_Select_Out,
        output Busy_Out,
        output Done_Out,
        output Scan_Data_Out
    );

    modport master (
        output Start_In,
        output Channel_Mask_In,
        output MUX_Data_In,
        input  MUX_Enable_Out,
        input  MUX_Select_Out,
        input  Busy_Out,
        input  Done_Out,
        input  Scan_Data_Out
    );
endinterface

// File: rtl/mux_channel_scanner.sv
// Walks the set bits of a 16-bit channel mask in ascending order through a 16:1 MUX,
// settling after every select change and then sampling one bit per channel into a result word.
//
// state  | meaning
// IDLE   | MUX disabled, waiting for Start_In
// SETTLE | select just changed, counting down settle cycles
// SAMPLE | one cycle; MUX_Data_In captured at its ending edge
// DONE   | one-cycle Done_Out pulse, Start_In ignored
module mux_channel_scanner #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  Clock_In,
    input  logic                  Reset_N_In,
    mux_channel_scanner_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);
    localparam logic       LP_NO_SETTLE = (SETTLE_CYCLES == 0);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [15:0] r_mask, w_mask_nxt;
    logic [15:0] r_shadow, w_shadow_nxt;
    logic [3:0]  r_sel, w_sel_nxt;
    logic        r_en, w_en_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;
    logic [15:0] r_data, w_data_nxt;

    logic [4:0]  w_first_bit;
    logic [4:0]  w_next_bit;
    logic [15:0] w_shadow_smp;

    // Lowest set mask bit at or above 'from'; bit 4 of the result flags "none left".
    function automatic logic [4:0] f_next_bit(input logic [15:0] mask, input logic [4:0] from);
        logic [4:0] res;
        res = 5'b10000;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i] && (5'(i) >= from)) res = {1'b0, 4'(i)};
        end
        return res;
    endfunction

    assign w_first_bit  = f_next_bit(bus.Channel_Mask_In, 5'd0);
    assign w_next_bit   = f_next_bit(r_mask, {1'b0, r_sel} + 5'd1);
    assign w_shadow_smp = (r_shadow & ~(16'h0001 << r_sel)) | (16'(bus.MUX_Data_In) << r_sel);

    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_mask   <= 16'h0000;
            r_shadow <= 16'h0000;
            r_sel    <= 4'd0;
            r_en     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_data   <= 16'h0000;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_mask   <= w_mask_nxt;
            r_shadow <= w_shadow_nxt;
            r_sel    <= w_sel_nxt;
            r_en     <= w_en_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_data   <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_mask_nxt   = r_mask;
        w_shadow_nxt = r_shadow;
        w_sel_nxt    = r_sel;
        w_en_nxt     = r_en;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_data_nxt   = r_data;

        case (r_state)
            IDLE: begin
                w_en_nxt   = 1'b0;
                w_sel_nxt  = 4'd0;
                w_busy_nxt = 1'b0;
                if (bus.Start_In) begin
                    if (bus.Channel_Mask_In != 16'h0000) begin
                        w_mask_nxt   = bus.Channel_Mask_In;
                        w_shadow_nxt = 16'h0000;
                        w_sel_nxt    = w_first_bit[3:0];
                        w_en_nxt     = 1'b1;
                        w_busy_nxt   = 1'b1;
                        w_cnt_nxt    = LP_SETTLE;
                        w_state_nxt  = LP_NO_SETTLE ? SAMPLE : SETTLE;
                    end else begin
                        w_data_nxt  = 16'h0000;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
            end
            SETTLE: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                w_shadow_nxt = w_shadow_smp;
                if (!w_next_bit[4]) begin
                    w_sel_nxt   = w_next_bit[3:0];
                    w_cnt_nxt   = LP_SETTLE;
                    w_state_nxt = LP_NO_SETTLE ? SAMPLE : SETTLE;
                end else begin
                    w_data_nxt  = w_shadow_smp;
                    w_en_nxt    = 1'b0;
                    w_sel_nxt   = 4'd0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.MUX_Enable_Out = r_en;
    assign bus.MUX_Select_Out = r_sel;
    assign bus.Busy_Out       = r_busy;
    assign bus.Done_Out       = r_done;
    assign bus.Scan_Data_Out  = r_data;

endmodule
